// File: rtl/shift_add_multiplier_mac_6.sv
// shift_add_multiplier_mac_6
//   Sequential 6x6 unsigned shift-add multiplier with an optional 12-bit
//   multiply-accumulate. A single 6-bit carry-lookahead adder slice carries
//   every add: six partial-product adds per multiply, then two passes
//   (low half, high half with carry) for the accumulate.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high
//   start    in   request, accepted in IDLE or DONE
//   mac      in   accumulate product into acc (sampled with start)
//   clr      in   clear acc/acc_ovf (honoured in IDLE or DONE)
//   a, b     in   6-bit multiplicand / multiplier
//   busy     out  high in RUN, ACC_LO, ACC_HI
//   done     out  one-cycle pulse, result valid
//   product  out  12-bit a*b, held until the next multiply completes
//   acc      out  12-bit accumulator (mod 4096)
//   acc_ovf  out  sticky carry-out of the accumulate

// 6-bit carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms rather than rippling through the lower carries.
module carry_look_ahead_adder_cin_cout_6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);
  logic [5:0] g, p;
  logic [6:0] c;
  logic       c_n, pp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c_n  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 6; i++) begin
      c_n = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_n = c_n | (pp & g[j]);
        pp  = pp & p[j];
      end
      c_n    = c_n | (pp & cin);
      c[i+1] = c_n;
    end
  end

  assign sum  = p ^ c[5:0];
  assign cout = c[6];
endmodule

module shift_add_multiplier_mac_6 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mac,
  input  logic        clr,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        busy,
  output logic        done,
  output logic [11:0] product,
  output logic [11:0] acc,
  output logic        acc_ovf
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    ACC_LO = 3'd2,
    ACC_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] m, mq, h;
  logic [2:0] cnt;
  logic       carry, mac_q;

  logic [5:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic [11:0] shifted;

  carry_look_ahead_adder_cin_cout_6 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // {cout, R, MQ} shifted right by one: the carry becomes H's MSB and the
  // LSB of MQ (already consumed) drops out.
  assign shifted = {add_cout, add_sum, mq[5:1]};

  // Adder operand steering; the slice is shared by all states.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      RUN: begin
        add_a = h;
        add_b = mq[0] ? m : 6'd0;
      end
      ACC_LO: begin
        add_a = acc[5:0];
        add_b = product[5:0];
      end
      ACC_HI: begin
        add_a   = acc[11:6];
        add_b   = product[11:6];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'd5) state_nxt = mac_q ? ACC_LO : DONE;
      end
      ACC_LO: begin
        busy      = 1'b1;
        state_nxt = ACC_HI;
      end
      ACC_HI: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m       <= '0;
      mq      <= '0;
      h       <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      mac_q   <= 1'b0;
      product <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // clr and start may coincide: acc is cleared now, so a following
          // mac result equals the new product.
          if (clr) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
          end
          if (start) begin
            m     <= a;
            mq    <= b;
            h     <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            mac_q <= mac;
          end
        end
        RUN: begin
          {h, mq} <= shifted;
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd5) product <= shifted;
        end
        ACC_LO: begin
          acc[5:0] <= add_sum;
          carry    <= add_cout;
        end
        ACC_HI: begin
          acc[11:6] <= add_sum;
          if (add_cout) acc_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier_mac_6.sv
// Self-checking bench for shift_add_multiplier_mac_6: directed cases followed
// by randomized operations, checked against an arithmetic model of the
// product and accumulator.
module tb_shift_add_multiplier_mac_6;
  logic        clk = 1'b0;
  logic        reset, start, mac, clr;
  logic [5:0]  a, b;
  logic        busy, done, acc_ovf;
  logic [11:0] product, acc;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  int unsigned acc_m = 0;
  bit          ovf_m = 1'b0;

  shift_add_multiplier_mac_6 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mac     (mac),
    .clr     (clr),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .acc     (acc),
    .acc_ovf (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic idle_in();
    start = 1'b0; mac = 1'b0; clr = 1'b0; a = '0; b = '0;
  endtask

  // Called at a negedge; drives a start for the coming edge (cycle 0), then
  // samples each following cycle at the negedge until done. noise=1 pulses
  // start with a=b=1 in cycles 3 and 6, which must be ignored.
  task automatic run_op(input int unsigned ia, input int unsigned ib,
                        input bit imac, input bit iclr, input bit noise);
    int unsigned p_exp, sum, lat, busy_cnt, i;
    bit seen;
    start = 1'b1; mac = imac; clr = iclr; a = ia[5:0]; b = ib[5:0];
    p_exp = ia * ib;
    if (iclr) begin acc_m = 0; ovf_m = 1'b0; end
    if (imac) begin
      sum   = acc_m + p_exp;
      if (sum >= 4096) ovf_m = 1'b1;
      acc_m = sum % 4096;
    end
    lat      = imac ? 9 : 7;
    busy_cnt = 0;
    seen     = 1'b0;
    i        = 0;
    while (!seen && i < 20) begin
      @(negedge clk);
      i++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      idle_in();
      if (noise && (i == 3 || i == 6)) begin
        start = 1'b1; a = 6'd1; b = 6'd1;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", i, lat);
    chk("busy_cycles", busy_cnt, lat - 1);
    chk("busy_at_done", busy, 0);
    chk("product", product, p_exp);
    chk("acc", acc, acc_m);
    chk("acc_ovf", acc_ovf, ovf_m);
  endtask

  task automatic quiet_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("quiet_done", done, 0);
      chk("quiet_busy", busy, 0);
    end
  endtask

  initial begin
    int unsigned ra, rb, lastp;
    bit rm, rc;
    idle_in();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", acc_ovf, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic multiplies and boundaries
    run_op(5, 3, 0, 0, 0);
    quiet_cycles(1);
    run_op(63, 63, 0, 0, 0);
    run_op(0, 42, 0, 0, 0);
    run_op(42, 1, 0, 0, 0);
    quiet_cycles(2);

    // MAC with overflow
    run_op(63, 63, 1, 1, 0);
    chk("mac1_acc", acc, 12'hF81);
    run_op(63, 63, 1, 0, 0);
    chk("mac2_acc", acc, 12'hF02);
    chk("mac2_ovf", acc_ovf, 1);
    run_op(1, 1, 1, 0, 0);
    chk("mac3_acc", acc, 12'hF03);
    chk("mac3_ovf", acc_ovf, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    acc_m = 0; ovf_m = 1'b0;
    chk("clr_acc", acc, 0);
    chk("clr_ovf", acc_ovf, 0);

    // Start while busy: only the first request runs
    @(negedge clk);
    run_op(7, 9, 0, 0, 1);
    quiet_cycles(10);

    // Back-to-back, second start in DONE with clr
    run_op(5, 5, 1, 0, 0);
    run_op(2, 3, 1, 1, 0);
    chk("b2b_acc", acc, 6);
    @(negedge clk);

    // clr is ignored while busy
    start = 1'b1; mac = 1'b0; a = 6'd3; b = 6'd3;
    @(negedge clk);
    idle_in();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("clr_busy_ign", acc, acc_m);

    // Reset in cycle 4 of a mac operation
    start = 1'b1; mac = 1'b1; a = 6'd11; b = 6'd13;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle_in();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    acc_m = 0; ovf_m = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_product", product, 0);
    chk("rmid_acc", acc, 0);
    chk("rmid_ovf", acc_ovf, 0);
    quiet_cycles(12);

    // Randomized operations, sometimes back-to-back
    for (int n = 0; n < 60; n++) begin
      ra = $urandom_range(63);
      rb = $urandom_range(63);
      rm = $urandom_range(1);
      rc = ($urandom_range(7) == 0);
      run_op(ra, rb, rm, rc, $urandom_range(1));
      if ($urandom_range(1)) begin
        lastp = ra * rb;
        @(negedge clk);
        chk("rnd_hold_product", product, lastp);
        chk("rnd_hold_acc", acc, acc_m);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
